// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
// Operands come straight from the register file read ports. The unit owns the
// architectural HI and LO registers. One radix-2 step is performed per cycle
// (shift-add for multiply, restoring division for divide), followed by a
// single sign-correction cycle that writes HI/LO and pulses done.
//
// Optional build macro: MDU_DIV_ZERO_DETECT_EN
//   When defined, DIV/DIVU with a zero divisor bypasses the iteration phase,
//   produces hi=operand_a / lo=all ones after one cycle and raises div_zero
//   alongside done.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      launch an operation (accepted only while idle)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   operand_a  rs value: multiplicand / dividend / MTHI-MTLO source
//   operand_b  rt value: multiplier / divisor
//   mthi_en    write operand_a into HI (idle only)
//   mtlo_en    write operand_a into LO (idle only)
//   busy       high while an operation is in flight
//   done       one-cycle pulse when HI/LO take a new result
//   hi, lo     architectural HI / LO registers
//   div_zero   (macro builds only) divide-by-zero flag, valid with done

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               sign_a_in;
    logic               sign_b_in;
    logic [WIDTH-1:0]   abs_a_in;
    logic [WIDTH-1:0]   abs_b_in;
    logic               zero_div_in;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MDU_DIV_ZERO_DETECT_EN
    logic               dz_q;
    logic               div_zero_q;
    assign zero_div_in = op[1] && (operand_b == '0);
    assign div_zero    = div_zero_q;
`else
    assign zero_div_in = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand conditioning at launch: signed ops (op[0]=0) work on magnitudes
    // and remember the signs so the final cycle can correct the result.
    always_comb begin
        sign_a_in = ~op[0] & operand_a[WIDTH-1];
        sign_b_in = ~op[0] & operand_b[WIDTH-1];
        abs_a_in  = sign_a_in ? (~operand_a + 1'b1) : operand_a;
        abs_b_in  = sign_b_in ? (~operand_b + 1'b1) : operand_b;
    end

    // One radix-2 iteration.
    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand into the upper half when the current multiplier bit is set,
    // then shift the whole thing right.
    // Divide: acc = {partial remainder, remaining dividend / quotient bits};
    // shift left, trial-subtract the divisor, keep it if there was no borrow.
    // The trial is one bit wider than the shifted remainder so a zero divisor
    // never looks like a borrow; that makes x/0 give quotient all ones and the
    // remainder equal to the dividend.
    always_comb begin
        acc_step  = acc;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, mag_b};
        if (is_div) begin
            if (!div_trial[WIDTH+1]) begin
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Final sign correction. Quotient/product are negated when the operand
    // signs differ; the remainder follows the sign of the dividend.
    always_comb begin
        prod_fix = neg_main ? (~acc + 1'b1) : acc;
        quot_fix = neg_main ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: WIDTH iterations in CALC, then one FIN cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = zero_div_in ? FIN : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(WIDTH - 1)) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers. Moves to HI/LO are honoured only in IDLE and lose to
    // a simultaneous start; HI/LO otherwise change only in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            count      <= '0;
            is_div     <= 1'b0;
            neg_main   <= 1'b0;
            neg_rem    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            div_zero_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        mag_a    <= abs_a_in;
                        mag_b    <= abs_b_in;
                        neg_main <= sign_a_in ^ sign_b_in;
                        neg_rem  <= sign_a_in;
                        count    <= '0;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a_in : abs_b_in)};
`ifdef MDU_DIV_ZERO_DETECT_EN
                        dz_q     <= zero_div_in;
                        if (zero_div_in) begin
                            acc      <= {operand_a, {WIDTH{1'b1}}};
                            neg_main <= 1'b0;
                            neg_rem  <= 1'b0;
                        end
`endif
                    end else begin
                        if (mthi_en) begin
                            hi_q <= operand_a;
                        end
                        if (mtlo_en) begin
                            lo_q <= operand_a;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIN: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
`ifdef MDU_DIV_ZERO_DETECT_EN
                    div_zero_q <= dz_q;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: a table of directed vectors, a few
// hand-written multi-cycle sequences (ignored start/move while busy, HI/LO
// moves, asynchronous reset mid-operation) and randomized operations checked
// against an arithmetic reference model.

module tb_mult_div_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int LAT   = WIDTH + 1;
`ifdef MDU_DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mthi_en;
    logic             mtlo_en;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_DIV_ZERO_DETECT_EN
    logic             div_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    mult_div_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .mthi_en   (mthi_en),
        .mtlo_en   (mtlo_en),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
`ifdef MDU_DIV_ZERO_DETECT_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference results straight from the arithmetic definitions: {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [1:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin
                p = sa * sb;
                return p;
            end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Waits for done, counting edges and busy cycles; lat stays -1 on timeout.
    task automatic wait_done(input int budget, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Launches one operation and checks handshake timing and the result.
    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input string name,
                                  input logic [31:0] ehi, input logic [31:0] elo);
        int lat, busy_cnt, exp_lat;
        exp_lat = (DZ_EN && o[1] && (b == 32'd0)) ? 1 : LAT;
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output({name, " busy_at_accept"}, busy, 1);
        check_output({name, " done_low_at_accept"}, done, 0);
        wait_done(LAT + 8, lat, busy_cnt);
        busy_cnt += 1;
        check_output({name, " latency"}, lat, exp_lat);
        check_output({name, " busy_cycles"}, busy_cnt, exp_lat);
        check_output({name, " hi"}, hi, ehi);
        check_output({name, " lo"}, lo, elo);
`ifdef MDU_DIV_ZERO_DETECT_EN
        check_output({name, " div_zero"}, div_zero, (o[1] && (b == 32'd0)));
`endif
    endtask

    initial begin
        int lat, busy_cnt, k;
        logic [31:0] prev_hi, prev_lo;
        logic [63:0] r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        mthi_en   = 1'b0;
        mtlo_en   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy", busy, 0);
        check_output("reset done", done, 0);
        check_output("reset hi", hi, 0);
        check_output("reset lo", lo, 0);
`ifdef MDU_DIV_ZERO_DETECT_EN
        check_output("reset div_zero", div_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, issued back to back.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b,
                           $sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end
        prev_hi = vecs[8].hi;
        prev_lo = vecs[8].lo;

        // DIVU in flight; start with new operands plus both moves at CALC cycle 10.
        @(negedge clk);
        start = 1'b1; op = 2'b11; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_a = 32'h1234_5678; operand_b = 32'd5;
        mthi_en = 1'b1; mtlo_en = 1'b1;
        @(posedge clk);
        #1;
        k++;
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
        check_output("ignore busy", busy, 1);
        check_output("ignore hi_held", hi, prev_hi);
        check_output("ignore lo_held", lo, prev_lo);
        wait_done(LAT + 8, lat, busy_cnt);
        check_output("ignore latency", (lat < 0) ? -1 : k + lat, LAT);
        check_output("ignore hi", hi, 32'd1);
        check_output("ignore lo", lo, 32'd333);
        @(posedge clk);
        #1;
        check_output("done pulse width", done, 0);
        check_output("busy after done", busy, 0);

        // Idle moves into both HI and LO.
        @(negedge clk);
        operand_a = 32'h1234_5678; mthi_en = 1'b1; mtlo_en = 1'b1;
        @(posedge clk);
        #1;
        mthi_en = 1'b0; mtlo_en = 1'b0;
        check_output("move hi", hi, 32'h1234_5678);
        check_output("move lo", lo, 32'h1234_5678);

        // Start and a move in the same idle cycle: the move is dropped.
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_a = 32'd3; operand_b = 32'd4; mthi_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mthi_en = 1'b0;
        check_output("start_wins hi_held", hi, 32'h1234_5678);
        wait_done(LAT + 8, lat, busy_cnt);
        check_output("start_wins latency", lat, LAT);
        check_output("start_wins hi", hi, 32'd0);
        check_output("start_wins lo", lo, 32'd12);

        // Asynchronous reset in the middle of a MULT.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand_a = 32'hFFFF_FFFB; operand_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("async busy", busy, 0);
        check_output("async done", done, 0);
        check_output("async hi", hi, 0);
        check_output("async lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(2'b01, 32'd6, 32'd7, "after_reset", 32'd0, 32'd42);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
            else rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if (!DZ_EN && (ro == 2'b10) && (rb == 32'd0)) rb = 32'd1;
            r = ref_model(ro, ra, rb);
            apply_stimulus(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro), r[63:32], r[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits directly downstream of the register file: consumes read_data_1 as operand_a and read_data_2 as operand_b.
- Owns the architectural HI/LO registers.
- Multi-cycle with a start/busy/done handshake; the controller stalls MFHI/MFLO while busy=1.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch an operation; accepted only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- operand_a  input  WIDTH  rs value: multiplicand or dividend.
- operand_b  input  WIDTH  rt value: multiplier or divisor.
- mthi_en  input  1  write operand_a into HI.
- mtlo_en  input  1  write operand_a into LO.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO take a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (asserted at any time, including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: busy=0. If start=1, latch op, the operand magnitudes and the sign flags, clear the accumulator, counter=0, go to CALC.
  - CALC: busy=1. One radix-2 iteration per cycle. After the WIDTH-th iteration go to FIN.
  - FIN: busy=1. Apply sign correction, write hi/lo, pulse done=1, return to IDLE.
- Latency: start sampled at edge N; busy=1 from N+1 through N+WIDTH+1. hi/lo update and done=1 occur at edge N+WIDTH+1, i.e. WIDTH+1 cycles. busy=0 and done=0 in the cycle after that.
- Back-to-back: a new start is accepted in the cycle following done.
- Multiply: shift-add on unsigned magnitudes into a 2*WIDTH-bit product. For MULT, negate the product when the operand signs differ. {hi,lo} = product.
- Divide: restoring division on unsigned magnitudes.
  - DIV: quotient negated when the signs differ; remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. No trap.
- Unsigned ops (MULTU, DIVU) treat operands as unsigned; no sign correction.
- start while busy=1: ignored. Operands are never re-sampled during CALC.
- mthi_en/mtlo_en while IDLE: hi or lo <= operand_a at the next edge. Both may be asserted together; both registers are written.
- mthi_en/mtlo_en while busy=1: ignored; the result is not corrupted.
- start and mthi_en/mtlo_en in the same IDLE cycle: start wins and the move is dropped.
- hi/lo hold their value while busy=1 and reflect the previous result until done.

Optional Feature:
- Macro: MDU_DIV_ZERO_DETECT_EN.
- Defined:
  - DIV or DIVU with operand_b=0 skips CALC: IDLE -> FIN directly, so done=1 at edge N+1.
  - Result: hi=operand_a, lo=all ones.
  - Extra output port div_zero (1 bit) is high in the same cycle as done for this case, otherwise 0; reset value 0.
- Not defined:
  - No div_zero port; divide by zero runs the full WIDTH+1 cycles.
  - DIVU yields hi=operand_a, lo=all ones.
  - DIV yields the algorithm's sign-corrected value. It is deterministic but the bench does not check it.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at start+33 cycles; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then DIVU a=100, b=7 -> lo=14, hi=2, with start issued the cycle after done.
- Start DIVU, assert start with new operands and mthi_en=1 at cycle 10 of CALC -> both ignored; original result delivered; hi/lo unchanged until done. Then in IDLE: mthi_en=1 and mtlo_en=1 with a=0x12345678 -> hi=lo=0x12345678.
- Start MULT, drop rst_n low at cycle 15 -> busy, done, hi, lo all 0 immediately (asynchronous). After release, start MULTU 6*7 -> lo=42, hi=0.
- DIVU a=0xDEADBEEF, b=0:
  - With MDU_DIV_ZERO_DETECT_EN: done and div_zero at start+1; hi=0xDEADBEEF, lo=0xFFFFFFFF.
  - Without the macro: done at start+33 with the same values.
